// File: rtl/carrot_demo_top.sv
// Carrot-Inside board demo: 6-LED running light plus a periodic "Hello\r\n" sent over
// an 8N1 UART transmitter. All logic is on clk_50m with a synchronous active-low reset.
module carrot_demo_top #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int LED_TICK     = 25_000_000,
  parameter int MSG_INTERVAL = 5_000_000
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  output logic [5:0] led,
  output logic       uart_tx_path
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int LED_W    = (LED_TICK > 1) ? $clog2(LED_TICK) : 1;
  localparam int MSG_W    = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(LED_TICK - 1);
  localparam logic [MSG_W-1:0]  MSG_LAST  = MSG_W'(MSG_INTERVAL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;

  // NOTE: the message is a constant function, not a register array, so it needs no reset.
  function automatic logic [7:0] msg_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h48;
      3'd1:    return 8'h65;
      3'd2:    return 8'h6C;
      3'd3:    return 8'h6C;
      3'd4:    return 8'h6F;
      3'd5:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // LED stepper: the wrap is registered, so the first rotation lands exactly on cycle LED_TICK.
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;
  logic             led_step_q, led_step_d;
  logic [5:0]       led_pat_q, led_pat_d;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    led_step_d = (led_cnt_q == LED_LAST);
    led_cnt_d  = led_step_d ? '0 : led_cnt_q + LED_W'(1);
    led_pat_d  = led_step_q ? {led_pat_q[4:0], led_pat_q[5]} : led_pat_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      led_cnt_q  <= '0;
      led_step_q <= 1'b0;
      led_pat_q  <= 6'b000001;
    end else begin
      led_cnt_q  <= led_cnt_d;
      led_step_q <= led_step_d;
      led_pat_q  <= led_pat_d;
    end
  end

  // Free-running trigger: fires on cycle 0 and every MSG_INTERVAL cycles after.
  logic [MSG_W-1:0] msg_cnt_q, msg_cnt_d;
  logic             trigger;

  always_comb begin
    trigger   = (msg_cnt_q == '0);
    msg_cnt_d = (msg_cnt_q == MSG_LAST) ? '0 : msg_cnt_q + MSG_W'(1);
  end

  always_ff @(posedge clk_50m) begin
    if (!reset_n) msg_cnt_q <= '0;
    else          msg_cnt_q <= msg_cnt_d;
  end

  // Message sequencer and UART transmitter share one FSM; triggers while busy fall through.
  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  always_ff @(posedge clk_50m) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    bit_end    = (baud_cnt_q == BAUD_LAST);
    state_d    = state_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (trigger) begin
          state_d    = ST_START;
          byte_idx_d = 3'd0;
          shift_d    = msg_byte(3'd0);
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      default: begin
        if (bit_end) begin
          if (byte_idx_q == 3'd6) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = msg_byte(byte_idx_q + 3'd1);
          end
        end
      end
    endcase
  end

  // Line level is decoded from the next state so the pin register changes with the bit.
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign led          = ~led_pat_q;
  assign uart_tx_path = tx_q;

endmodule

// File: tb/tb_carrot_demo_top.sv
// Bench for carrot_demo_top: four instances with different parameters run side by side,
// UART frames are decoded and scored against the expected "Hello\r\n" byte queue.
module tb_carrot_demo_top;

  logic       clk = 1'b0;
  logic       rst_n, rst_n_r;
  logic [5:0] led_def, led_fast, led_busy, led_rst;
  logic       tx_def, tx_fast, tx_busy, tx_rst;
  int         tcyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  carrot_demo_top u_def (
    .clk_50m(clk), .reset_n(rst_n), .led(led_def), .uart_tx_path(tx_def)
  );
  carrot_demo_top #(.BAUD(5_000_000), .LED_TICK(10), .MSG_INTERVAL(1000)) u_fast (
    .clk_50m(clk), .reset_n(rst_n), .led(led_fast), .uart_tx_path(tx_fast)
  );
  carrot_demo_top #(.BAUD(5_000_000), .LED_TICK(10), .MSG_INTERVAL(200)) u_busy (
    .clk_50m(clk), .reset_n(rst_n), .led(led_busy), .uart_tx_path(tx_busy)
  );
  carrot_demo_top #(.BAUD(5_000_000), .LED_TICK(10), .MSG_INTERVAL(1000)) u_rst (
    .clk_50m(clk), .reset_n(rst_n_r), .led(led_rst), .uart_tx_path(tx_rst)
  );

  typedef struct {
    int         cyc;
    logic [5:0] led;
  } led_vec_t;

  function automatic logic line_of(input int sel);
    case (sel)
      0:       return tx_def;
      1:       return tx_fast;
      2:       return tx_busy;
      default: return tx_rst;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a start bit, then samples each bit at its centre.
  task automatic rx_frame(input int sel, input int div, input int budget,
                          output logic [7:0] b, output int start_tc, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    b = '0;
    start_tc = 0;
    while (line_of(sel) !== 1'b0) begin
      if (n >= budget) return;
      step();
      n++;
    end
    start_tc = tcyc;
    repeat (div / 2) step();
    if (line_of(sel) !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (div) step();
      b[i] = line_of(sel);
    end
    repeat (div) step();
    if (line_of(sel) !== 1'b1) return;
    ok = 1'b1;
  endtask

  task automatic check_msg(input string tag, input int sel, input int div, input int t0,
                           input int exp_start, input int budget);
    logic [7:0] hello [7];
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic [7:0] e;
    int         st, cyc, prev;
    bit         ok;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
    foreach (hello[i]) exp_q.push_back(hello[i]);
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      rx_frame(sel, div, (k == 0) ? budget : 3 * div, b, st, ok);
      check($sformatf("%s_frame%0d_ok", tag, k), {31'd0, ok}, 32'd1);
      if (!ok) return;
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, e});
      cyc = st - t0 - 1;
      if (k == 0) check_range({tag, "_start_cycle"}, cyc, exp_start, exp_start + 2);
      else        check_range($sformatf("%s_gap%0d", tag, k), cyc - (prev + 10 * div), 0, 2);
      prev = cyc;
    end
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog expired actual=%0d required<%0d cycles", tcyc, 70000);
    $fatal(1, "watchdog");
  end

  initial begin
    led_vec_t led_tbl [9];
    int       t0, t1, lows;
    led_tbl[0] = '{0,  6'b111110};
    led_tbl[1] = '{9,  6'b111110};
    led_tbl[2] = '{10, 6'b111101};
    led_tbl[3] = '{20, 6'b111011};
    led_tbl[4] = '{30, 6'b110111};
    led_tbl[5] = '{40, 6'b101111};
    led_tbl[6] = '{50, 6'b011111};
    led_tbl[7] = '{59, 6'b011111};
    led_tbl[8] = '{60, 6'b111110};

    rst_n   = 1'b0;
    rst_n_r = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_led_def",  {26'd0, led_def},  32'h3E);
    check("rst_tx_def",   {31'd0, tx_def},   32'd1);
    check("rst_led_fast", {26'd0, led_fast}, 32'h3E);
    check("rst_tx_fast",  {31'd0, tx_fast},  32'd1);
    check("rst_tx_busy",  {31'd0, tx_busy},  32'd1);
    check("rst_tx_rst",   {31'd0, tx_rst},   32'd1);

    @(negedge clk);
    rst_n   = 1'b1;
    rst_n_r = 1'b1;
    t0      = tcyc;
    step();

    fork
      begin
        check_msg("def", 0, 434, t0, 0, 4);
        lows = 0;
        while (tcyc - t0 - 1 < 35000) begin
          step();
          if (tx_def !== 1'b1) lows++;
        end
        check("def_idle_low_cycles", lows, 0);
        check("def_led_unchanged", {26'd0, led_def}, 32'h3E);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          while (tcyc - t0 - 1 < led_tbl[i].cyc) step();
          check($sformatf("led_step_c%0d", led_tbl[i].cyc), {26'd0, led_fast},
                {26'd0, led_tbl[i].led});
        end
      end
      begin
        check_msg("fast0", 1, 10, t0, 0, 4);
        check_msg("fast1", 1, 10, t0, 1000, 1000);
        check_msg("fast2", 1, 10, t0, 2000, 1000);
      end
      begin
        check_msg("busy0", 2, 10, t0, 0, 4);
        check_msg("busy1", 2, 10, t0, 800, 400);
      end
      begin
        logic [7:0] b;
        int         st;
        bit         ok;
        logic [7:0] pre [3];
        pre = '{8'h48, 8'h65, 8'h6C};
        for (int k = 0; k < 3; k++) begin
          rx_frame(3, 10, (k == 0) ? 4 : 30, b, st, ok);
          check($sformatf("rst_pre_byte%0d", k), {23'd0, ok, b}, {23'd0, 1'b1, pre[k]});
        end
        while (tcyc - t0 - 1 < 325) step();
        check("rst_mid_frame_low", {31'd0, tx_rst}, 32'd0);
        @(negedge clk);
        rst_n_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
          step();
          check($sformatf("rst_mid_tx%0d", k), {31'd0, tx_rst}, 32'd1);
          check($sformatf("rst_mid_led%0d", k), {26'd0, led_rst}, 32'h3E);
        end
        @(negedge clk);
        rst_n_r = 1'b1;
        t1      = tcyc;
        step();
        check_msg("rst_resend", 3, 10, t1, 0, 4);
      end
    join

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
